// File: rtl/data_mem_ctrl_pkg.sv
// Shared opcodes, funct3 codes and state encoding for the data-side memory controller.
package data_mem_ctrl_pkg;

  localparam logic [6:0] LD_TYPE = 7'b0000011;
  localparam logic [6:0] ST_TYPE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

  // Number of bytes moved for a given access width.
  function automatic logic [2:0] access_len(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: access_len = 3'd1;
      F3_H, F3_HU: access_len = 3'd2;
      F3_W:        access_len = 3'd4;
      default:     access_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_extend.sv
// Sign/zero extension of an assembled little-endian load word.
module load_extend
  import data_mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (funct3)
      F3_B:    result = {{24{raw[7]}}, raw[7:0]};
      F3_H:    result = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   result = {24'd0, raw[7:0]};
      F3_HU:   result = {16'd0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: serialises LSB loads/stores into byte accesses
// on a shared 8-bit RAM port and returns extended load results.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,
  input  logic        lsb_visit_mem,
  input  logic [6:0]  op_type_in,
  input  logic [2:0]  op_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_val_in,
  output logic        cache_welcome_signal,
  output logic        cache_ready,
  output logic        is_load,
  output logic [31:0] load_val_out,
  output logic        mem_req,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mem_state_t  state_reg, state_next;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] store_val_reg;
  logic [2:0]  len_reg;
  logic [2:0]  cnt_reg;
  logic [31:0] raw_reg;
  logic        cap_pending_reg;
  logic        is_load_reg;
  logic [31:0] load_val_reg;

  logic        accept;
  logic        access;
  logic        last_access;
  logic [31:0] raw_merged;
  logic [31:0] ext_val;

  assign cache_welcome_signal = (state_reg == IDLE) && rst_n_in && !rob_clear_up;
  assign accept       = cache_welcome_signal && lsb_visit_mem && rdy_in;
  assign cache_ready  = (state_reg == DONE);
  assign is_load      = is_load_reg;
  assign load_val_out = load_val_reg;

  // A UART-bound store may only proceed while the UART can take the byte.
  always_comb begin
    access = 1'b0;
    case (state_reg)
      LOAD:    access = mem_gnt && rdy_in && (cnt_reg < len_reg);
      STORE:   access = mem_gnt && rdy_in && !((addr_reg >= IO_BASE) && io_buffer_full);
      default: access = 1'b0;
    endcase
  end

  assign last_access = access && ((cnt_reg + 3'd1) == len_reg);

  // Byte k arrives one cycle after its access, when cnt_reg already reads k+1.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign raw_merged[gi*8 +: 8] = (cap_pending_reg && (cnt_reg == 3'(gi + 1)))
                                   ? mem_din : raw_reg[gi*8 +: 8];
  end

  load_extend u_load_extend (
    .funct3 (funct3_reg),
    .raw    (raw_merged),
    .result (ext_val)
  );

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_a      = '0;
    mem_dout   = '0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = (op_type_in == ST_TYPE) ? STORE : LOAD;
      end
      LOAD: begin
        mem_req = (cnt_reg < len_reg);
        mem_a   = addr_reg + {29'd0, cnt_reg};
        if (rob_clear_up) begin
          state_next = IDLE;
        end else if (rdy_in && (cnt_reg == len_reg)) begin
          state_next = DONE;
        end
      end
      STORE: begin
        // Stores are already committed, so a flush does not stop them.
        mem_req  = 1'b1;
        mem_wr   = access;
        mem_a    = addr_reg + {29'd0, cnt_reg};
        mem_dout = store_val_reg[{cnt_reg[1:0], 3'b000} +: 8];
        if (last_access) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      funct3_reg      <= '0;
      addr_reg        <= '0;
      store_val_reg   <= '0;
      len_reg         <= '0;
      cnt_reg         <= '0;
      raw_reg         <= '0;
      cap_pending_reg <= 1'b0;
      is_load_reg     <= 1'b0;
      load_val_reg    <= '0;
    end else begin
      cap_pending_reg <= (state_reg == LOAD) && access && !rob_clear_up;
      if (accept) begin
        funct3_reg    <= op_in;
        addr_reg      <= addr_in;
        store_val_reg <= store_val_in;
        len_reg       <= access_len(op_in);
        cnt_reg       <= '0;
        raw_reg       <= '0;
      end else begin
        if (cap_pending_reg) raw_reg <= raw_merged;
        if (access) cnt_reg <= cnt_reg + 3'd1;
      end
      if ((state_next == DONE) && (state_reg != DONE)) begin
        is_load_reg  <= (state_reg == LOAD);
        load_val_reg <= (state_reg == LOAD) ? ext_val : '0;
      end
    end
  end

endmodule
